// File: rtl/shift_register_pkg.sv
// ---------------------------------------------------------------------------
// shift_register_pkg
// Shared types and constants for the shift_register_xfer serialiser slice.
//   state_e   : transfer FSM encoding (IDLE / SHIFT)
//   ORDER_*   : per-transfer bit-order selector values (i_lsb_first)
// ---------------------------------------------------------------------------
package shift_register_pkg;

  // Transfer FSM encoding
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-order selector values as seen on i_lsb_first / dir_q
  localparam logic ORDER_MSB = 1'b0;
  localparam logic ORDER_LSB = 1'b1;

endpackage : shift_register_pkg

// File: rtl/shift_bit_counter.sv
// ---------------------------------------------------------------------------
// shift_bit_counter
// Counts shift edges within one transfer and flags the last bit position.
// Ports:
//   i_clk     : clock, rising edge
//   i_rstn    : synchronous active-low reset
//   i_clear   : restart the count at zero (transfer accept)
//   i_enable  : advance by one (each shift edge)
//   o_term_c  : combinational flag, high while the count equals BIT-1
// ---------------------------------------------------------------------------
module shift_bit_counter #(
  parameter int unsigned BIT   = 8,
  parameter int unsigned CNT_W = $clog2(BIT + 1)
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_term_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next-count: clear wins over enable
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last bit of the word is being sampled on the coming edge
  assign o_term_c = (cnt_q == CNT_W'(BIT - 1));

endmodule : shift_bit_counter

// File: rtl/shift_register_xfer.sv
// ---------------------------------------------------------------------------
// shift_register_xfer
// Full-duplex word serialiser/deserialiser with valid/ready word interface.
// A BIT-wide word is shifted out on o_serial while BIT bits are captured
// from i_serial; bit order is chosen per transfer.
// Ports:
//   i_clk, i_rstn : clock (rising edge), synchronous active-low reset
//   i_valid       : transfer request, qualifies i_parrel / i_lsb_first
//   o_ready       : request can be accepted (IDLE)
//   i_parrel      : word to transmit, sampled on accept
//   i_lsb_first   : 0 = MSB first, 1 = LSB first, sampled on accept
//   i_abort       : cancel the transfer in progress / block accept in IDLE
//   i_serial      : serial receive bit
//   o_serial      : serial transmit bit (from tx register, 0 when idle)
//   o_parrel      : last completed received word
//   o_done        : one-cycle pulse when o_parrel updates
//   o_busy        : transfer in progress (SHIFT)
// ---------------------------------------------------------------------------
module shift_register_xfer
  import shift_register_pkg::*;
#(
  parameter int unsigned BIT = 8
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [BIT-1:0] i_parrel,
  input  logic           i_lsb_first,
  input  logic           i_abort,
  input  logic           i_serial,
  output logic           o_serial,
  output logic [BIT-1:0] o_parrel,
  output logic           o_done,
  output logic           o_busy
);

  localparam int unsigned CNT_W = $clog2(BIT + 1);

  state_e         state_q, state_d;
  logic [BIT-1:0] tx_q, tx_d;
  logic [BIT-1:0] rx_q, rx_d;
  logic           dir_q, dir_d;
  logic [BIT-1:0] parrel_q, parrel_d;
  logic           done_q, done_d;

  logic           cnt_clr;
  logic           cnt_en;
  logic           last_bit_c;
  logic [BIT-1:0] tx_shift_c;
  logic [BIT-1:0] rx_shift_c;

  // Edge counter; terminal flag marks the edge that samples the last bit
  shift_bit_counter #(
    .BIT   (BIT),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_clear  (cnt_clr),
    .i_enable (cnt_en),
    .o_term_c (last_bit_c)
  );

  // Shifted views of the tx/rx registers for the active bit order
  always_comb begin
    if (dir_q == ORDER_LSB) begin
      tx_shift_c = {1'b0, tx_q[BIT-1:1]};
      rx_shift_c = {i_serial, rx_q[BIT-1:1]};
    end else begin
      tx_shift_c = {tx_q[BIT-2:0], 1'b0};
      rx_shift_c = {rx_q[BIT-2:0], i_serial};
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    dir_d    = dir_q;
    parrel_d = parrel_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Abort in IDLE suppresses an accept in the same cycle
        if (i_valid && !i_abort) begin
          tx_d    = i_parrel;
          dir_d   = i_lsb_first;
          rx_d    = '0;
          cnt_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Abort beats the completion edge: no pulse, o_parrel untouched
        if (i_abort) begin
          state_d = ST_IDLE;
        end else begin
          tx_d   = tx_shift_c;
          rx_d   = rx_shift_c;
          cnt_en = 1'b1;
          if (last_bit_c) begin
            parrel_d = rx_shift_c;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      dir_q    <= ORDER_MSB;
      parrel_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      dir_q    <= dir_d;
      parrel_q <= parrel_d;
      done_q   <= done_d;
    end
  end

  // Outputs: handshake/status decoded from the state register
  assign o_ready  = (state_q == ST_IDLE);
  assign o_busy   = (state_q == ST_SHIFT);
  assign o_serial = o_busy & ((dir_q == ORDER_LSB) ? tx_q[0] : tx_q[BIT-1]);
  assign o_parrel = parrel_q;
  assign o_done   = done_q;

endmodule : shift_register_xfer

// File: tb/tb_shift_register_xfer.sv
// ---------------------------------------------------------------------------
// tb_shift_register_xfer
// Scoreboarded bench for shift_register_xfer at BIT = 8, 16 and 2.
// Stimulus pushes expected serial bits and received words into queues;
// per-instance monitors pop and compare on busy cycles and o_done pulses.
// ---------------------------------------------------------------------------
module tb_shift_register_xfer;

  logic clk;
  logic rstn;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  // ---- BIT = 8 instance ----
  logic        v8, lsb8, ab8, ext8, lb8;
  logic [7:0]  d8;
  logic        rdy8, ser8, done8, busy8, sin8;
  logic [7:0]  par8;
  logic [7:0]  ext_seq8;
  // ---- BIT = 16 instance (loopback) ----
  logic        v16, lsb16, ab16;
  logic [15:0] d16;
  logic        rdy16, ser16, done16, busy16;
  logic [15:0] par16;
  // ---- BIT = 2 instance (loopback) ----
  logic        v2, lsb2, ab2;
  logic [1:0]  d2;
  logic        rdy2, ser2, done2, busy2;
  logic [1:0]  par2;

  logic sq8[$], sq16[$], sq2[$];
  logic [63:0] pq8[$], pq16[$], pq2[$];
  logic prev8 = 1'b0, prev16 = 1'b0, prev2 = 1'b0;

  assign sin8 = lb8 ? ser8 : ext8;

  shift_register_xfer #(.BIT(8)) u_dut8 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(v8), .o_ready(rdy8),
    .i_parrel(d8), .i_lsb_first(lsb8), .i_abort(ab8), .i_serial(sin8),
    .o_serial(ser8), .o_parrel(par8), .o_done(done8), .o_busy(busy8));

  shift_register_xfer #(.BIT(16)) u_dut16 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(v16), .o_ready(rdy16),
    .i_parrel(d16), .i_lsb_first(lsb16), .i_abort(ab16), .i_serial(ser16),
    .o_serial(ser16), .o_parrel(par16), .o_done(done16), .o_busy(busy16));

  shift_register_xfer #(.BIT(2)) u_dut2 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(v2), .o_ready(rdy2),
    .i_parrel(d2), .i_lsb_first(lsb2), .i_abort(ab2), .i_serial(ser2),
    .o_serial(ser2), .o_parrel(par2), .o_done(done2), .o_busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name, input string msg);
    total++;
    bad++;
    $display("FAIL %s: %s", name, msg);
  endfunction

  // ---- monitors ----
  always @(negedge clk) if (mon_en) begin
    if (busy8) begin
      if (sq8.size() == 0) fail("ser8", "busy with no expected bit");
      else chk("ser8", 64'(ser8), 64'(sq8.pop_front()));
    end else chk("ser8 idle", 64'(ser8), 64'd0);
    if (done8) begin
      chk("done8 ready", 64'(rdy8), 64'd1);
      chk("done8 width", 64'(prev8), 64'd0);
      if (pq8.size() == 0) fail("done8", "unexpected o_done");
      else chk("parrel8", 64'(par8), pq8.pop_front());
    end
    prev8 <= done8;
  end

  always @(negedge clk) if (mon_en) begin
    if (busy16) begin
      if (sq16.size() == 0) fail("ser16", "busy with no expected bit");
      else chk("ser16", 64'(ser16), 64'(sq16.pop_front()));
    end
    if (done16) begin
      chk("done16 width", 64'(prev16), 64'd0);
      if (pq16.size() == 0) fail("done16", "unexpected o_done");
      else chk("parrel16", 64'(par16), pq16.pop_front());
    end
    prev16 <= done16;
  end

  always @(negedge clk) if (mon_en) begin
    if (busy2) begin
      if (sq2.size() == 0) fail("ser2", "busy with no expected bit");
      else chk("ser2", 64'(ser2), 64'(sq2.pop_front()));
    end
    if (done2) begin
      chk("done2 width", 64'(prev2), 64'd0);
      if (pq2.size() == 0) fail("done2", "unexpected o_done");
      else chk("parrel2", 64'(par2), pq2.pop_front());
    end
    prev2 <= done2;
  end

  // ---- stimulus helpers ----
  task automatic push_ser(input int which, input logic [63:0] w, input logic lsb,
                          input int nbits, input int width);
    logic b;
    for (int k = 0; k < nbits; k++) begin
      b = lsb ? w[k] : w[width-1-k];
      if (which == 8) sq8.push_back(b);
      else if (which == 16) sq16.push_back(b);
      else sq2.push_back(b);
    end
  endtask

  task automatic start(input int which, input logic [63:0] w, input logic lsb, input logic hold);
    @(negedge clk);
    if (which == 8) begin v8 = 1'b1; d8 = 8'(w); lsb8 = lsb; end
    else if (which == 16) begin v16 = 1'b1; d16 = 16'(w); lsb16 = lsb; end
    else begin v2 = 1'b1; d2 = 2'(w); lsb2 = lsb; end
    @(posedge clk);
    #1;
    if (!hold) begin v8 = 1'b0; v16 = 1'b0; v2 = 1'b0; end
  endtask

  // Counts cycles after the accept edge until o_done; drives ext8 for BIT=8
  task automatic wait_done(input int which, input int exp_lat, input string name);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = (which == 8) ? done8 : (which == 16) ? done16 : done2;
      if (which == 8 && !seen && n <= 8) ext8 = ext_seq8[3'(n-1)];
    end
    if (!seen) fail(name, "o_done never asserted");
    else chk(name, 64'(n), 64'(exp_lat));
  endtask

  task automatic abort8(input logic [7:0] w, input int at_bit, input logic [7:0] hold_val);
    push_ser(8, 64'(w), 1'b0, at_bit + 1, 8);
    start(8, 64'(w), 1'b0, 1'b0);
    for (int n = 1; n <= at_bit; n++) @(negedge clk);
    @(negedge clk);
    ab8 = 1'b1;
    @(posedge clk);
    #1 ab8 = 1'b0;
    @(negedge clk);
    chk("abort busy", 64'(busy8), 64'd0);
    chk("abort ready", 64'(rdy8), 64'd1);
    chk("abort done", 64'(done8), 64'd0);
    chk("abort parrel", 64'(par8), 64'(hold_val));
  endtask

  // ---- main sequence ----
  initial begin
    rstn = 1'b0;
    v8 = 0; lsb8 = 0; ab8 = 0; ext8 = 0; lb8 = 1; d8 = '0; ext_seq8 = '0;
    v16 = 0; lsb16 = 0; ab16 = 0; d16 = '0;
    v2 = 0; lsb2 = 0; ab2 = 0; d2 = '0;
    repeat (2) @(negedge clk);
    chk("rst parrel8", 64'(par8), 64'd0);
    chk("rst done8", 64'(done8), 64'd0);
    chk("rst serial8", 64'(ser8), 64'd0);
    chk("rst ready8", 64'(rdy8), 64'd1);
    chk("rst busy8", 64'(busy8), 64'd0);
    chk("rst parrel16", 64'(par16), 64'd0);
    rstn = 1'b1;
    mon_en = 1'b1;

    // MSB-first loopback of C1
    push_ser(8, 64'hC1, 1'b0, 8, 8);
    pq8.push_back(64'hC1);
    start(8, 64'hC1, 1'b0, 1'b0);
    wait_done(8, 9, "lat msb8");

    // LSB-first, external receive bits 0,0,1,1,1,1,0,0 in time order
    lb8 = 1'b0;
    ext_seq8 = 8'b0011_1100;
    push_ser(8, 64'hC1, 1'b1, 8, 8);
    pq8.push_back(64'h3C);
    start(8, 64'hC1, 1'b1, 1'b0);
    wait_done(8, 9, "lat lsb8");
    lb8 = 1'b1;

    // Back-to-back: C1 then 5A with i_valid held
    push_ser(8, 64'hC1, 1'b0, 8, 8);
    push_ser(8, 64'h5A, 1'b0, 8, 8);
    pq8.push_back(64'hC1);
    pq8.push_back(64'h5A);
    start(8, 64'hC1, 1'b0, 1'b1);
    d8 = 8'h5A;
    wait_done(8, 9, "lat b2b first");
    chk("b2b ready", 64'(rdy8), 64'd1);
    @(posedge clk);
    #1 v8 = 1'b0;
    wait_done(8, 9, "lat b2b second");

    // Abort: load C1, then abort mid-word and on the completion edge
    push_ser(8, 64'hC1, 1'b0, 8, 8);
    pq8.push_back(64'hC1);
    start(8, 64'hC1, 1'b0, 1'b0);
    wait_done(8, 9, "lat pre-abort");
    abort8(8'h96, 4, 8'hC1);
    abort8(8'h3C, 7, 8'hC1);
    // Abort in IDLE blocks a simultaneous request
    @(negedge clk);
    v8 = 1'b1; ab8 = 1'b1; d8 = 8'hFF;
    @(posedge clk);
    #1 begin v8 = 1'b0; ab8 = 1'b0; end
    @(negedge clk);
    chk("idle abort busy", 64'(busy8), 64'd0);
    chk("idle abort parrel", 64'(par8), 64'hC1);
    // Normal request after abort
    push_ser(8, 64'h7E, 1'b1, 8, 8);
    pq8.push_back(64'h7E);
    start(8, 64'h7E, 1'b1, 1'b0);
    wait_done(8, 9, "lat post-abort");

    // Width sweep: BIT=16 both orders, BIT=2 corner
    push_ser(16, 64'hA50F, 1'b0, 16, 16);
    pq16.push_back(64'hA50F);
    start(16, 64'hA50F, 1'b0, 1'b0);
    wait_done(16, 17, "lat msb16");
    push_ser(16, 64'hA50F, 1'b1, 16, 16);
    pq16.push_back(64'hA50F);
    start(16, 64'hA50F, 1'b1, 1'b0);
    wait_done(16, 17, "lat lsb16");
    push_ser(2, 64'h2, 1'b0, 2, 2);
    pq2.push_back(64'h2);
    start(2, 64'h2, 1'b0, 1'b0);
    wait_done(2, 3, "lat msb2");
    push_ser(2, 64'h2, 1'b1, 2, 2);
    pq2.push_back(64'h2);
    start(2, 64'h2, 1'b1, 1'b0);
    wait_done(2, 3, "lat lsb2");
    push_ser(2, 64'h1, 1'b0, 2, 2);
    pq2.push_back(64'h1);
    start(2, 64'h1, 1'b0, 1'b0);
    wait_done(2, 3, "lat msb2 b");

    // Reset at bit 3 of an 8-bit transfer
    push_ser(8, 64'hE7, 1'b0, 4, 8);
    start(8, 64'hE7, 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid rst parrel", 64'(par8), 64'd0);
    chk("mid rst done", 64'(done8), 64'd0);
    chk("mid rst serial", 64'(ser8), 64'd0);
    chk("mid rst ready", 64'(rdy8), 64'd1);
    chk("mid rst busy", 64'(busy8), 64'd0);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid rst no done", 64'(done8), 64'd0);

    repeat (3) @(negedge clk);
    chk("sq8 empty", 64'(sq8.size()), 64'd0);
    chk("pq8 empty", 64'(pq8.size()), 64'd0);
    chk("sq16 empty", 64'(sq16.size()), 64'd0);
    chk("pq16 empty", 64'(pq16.size()), 64'd0);
    chk("sq2 empty", 64'(sq2.size()), 64'd0);
    chk("pq2 empty", 64'(pq2.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_shift_register_xfer

// File: doc/shift_register_xfer.md
# shift_register_xfer

Parametrised full-duplex serialiser/deserialiser, successor to the fixed 8-bit shift register. On each accepted request, a BIT-wide word is shifted out on `o_serial` while BIT bits are simultaneously captured from `i_serial`. The bit order is selectable per transfer, and a one-cycle `o_done` pulse marks completion. The block sits between word-oriented control logic and a bit-serial link (SPI-style data path), with a valid/ready handshake on the word side.

## Interface
- `BIT`, 8: word width in bits; legal range 2..64.
- `CNT_W`, $clog2(BIT+1): bit-counter width; localparam, not overridable.
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rstn`  in  1  reset; synchronous, active-low.
- `i_valid`  in  1  transfer request; qualifies `i_parrel` and `i_lsb_first`.
- `o_ready`  out  1  high when a request can be accepted (IDLE).
- `i_parrel`  in  BIT  word to transmit; sampled on accept.
- `i_lsb_first`  in  1  bit order for this transfer: 0 = MSB first, 1 = LSB first; sampled on accept.
- `i_abort`  in  1  cancels the transfer in progress.
- `i_serial`  in  1  serial receive bit.
- `o_serial`  out  1  serial transmit bit.
- `o_parrel`  out  BIT  last completed received word; holds until the next completion.
- `o_done`  out  1  one-cycle pulse when `o_parrel` has been updated.
- `o_busy`  out  1  high while in SHIFT.

## Operation
- **State machine:** IDLE, SHIFT.
- **IDLE:**
  - `o_ready`=1.
  - On `i_valid`&&`o_ready` (accept): `tx_q`<=`i_parrel`, `dir_q`<=`i_lsb_first`, `cnt`<=0, `rx_q`<=0, next state SHIFT.
- **SHIFT:**
  - `o_ready`=0, `o_busy`=1.
  - `o_serial` = `dir_q` ? `tx_q[0]` : `tx_q[BIT-1]`. This is combinational from `tx_q`; `o_serial` is 0 outside SHIFT.
  - Each edge, MSB first: `tx_q`<={`tx_q[BIT-2:0]`,0}; `rx_q`<={`rx_q[BIT-2:0]`,`i_serial`}.
  - Each edge, LSB first: `tx_q`<={0,`tx_q[BIT-1:1]`}; `rx_q`<={`i_serial`,`rx_q[BIT-1:1]`}.
  - `cnt`<=`cnt`+1 on each edge.
  - On the edge where `cnt`==BIT-1: `o_parrel`<= the shifted `rx_q` value, including the bit sampled on that edge. `o_done`<=1, next state IDLE.
- **Abort:**
  - `i_abort` in SHIFT: next state IDLE.
  - No `o_done`; `o_parrel` is unchanged.
  - Abort has priority over the completion edge.
  - In IDLE, `i_abort` blocks accept in the same cycle.
- **Back-to-back:** `i_valid` held high during the `o_done` cycle is accepted in that cycle. There is no idle gap beyond that cycle.
- **Other inputs:** `i_valid` while busy is ignored and not queued. `i_parrel` and `i_lsb_first` are don't-care except at accept.

## Timing
- **Reset** (`i_rstn`=0 at an edge, takes priority over everything including mid-transfer):
  - State=IDLE, `tx_q`=0, `rx_q`=0, `cnt`=0, `dir_q`=0.
  - Outputs: `o_parrel`=0, `o_done`=0, `o_serial`=0, `o_ready`=1, `o_busy`=0.
- **Accept at edge E:**
  - Bit k (k=0..BIT-1) is on `o_serial` during the cycle after edge E+k.
  - `i_serial` is sampled at edges E+1..E+BIT.
  - `o_parrel` is valid and `o_done`=1 in the cycle after edge E+BIT, in which `o_ready` is also 1.
- **Throughput:** one word per BIT+1 cycles when requests are back-to-back.
- **Pulse width:** `o_done` is exactly one cycle wide; it is never high in consecutive cycles.

## Structure
- **Package `shift_register_pkg`:**
  - State encoding: `ST_IDLE`=1'b0, `ST_SHIFT`=1'b1.
  - Bit-order constants: `ORDER_MSB`=0, `ORDER_LSB`=1.
- **Sub-module `shift_bit_counter`:**
  - Parameter CNT_W; inputs `i_clk`, `i_rstn`, clear, enable.
  - Output: terminal flag at BIT-1.
  - The rest stays in the top module.

## Test plan
- **MSB-first loopback:** BIT=8, `i_parrel`=8'hC1, `i_lsb_first`=0, `o_serial` looped to `i_serial` -> `o_serial` sequence 1,1,0,0,0,0,0,1; `o_parrel`=8'hC1 with `o_done` 9 cycles after accept.
- **LSB-first receive:** `i_parrel`=8'hC1, `i_lsb_first`=1, external `i_serial` sequence 0,0,1,1,1,1,0,0 -> `o_serial` sequence 1,0,0,0,0,0,1,1; `o_parrel`=8'h3C.
- **Back-to-back:** `i_valid` held high with 8'hC1 then 8'h5A -> second accept in the `o_done` cycle of the first; second `o_done` 9 cycles later; loopback `o_parrel`=8'h5A.
- **Abort:** abort at bit 4 of a transfer with `o_parrel` holding 8'hC1 -> IDLE next cycle, no `o_done`, `o_parrel` stays 8'hC1; a request in the following cycle completes normally.
- **Reset mid-transfer:** `i_rstn`=0 at bit 3 -> all outputs at reset values on the next cycle; `o_done` never asserts for the interrupted word.
- **Width sweep:** BIT=16, loopback 16'hA50F in both orders -> `o_parrel`=16'hA50F, `o_done` 17 cycles after accept; BIT=2 corner passes the same checks.
